// File: rtl/ntt_bram_pkg.sv
// Shared definitions for the NTT BRAM responder: default geometry of the
// word store and the host-side sequencer state encoding.
package ntt_bram_pkg;

   localparam int DATA_W_DEF = 64;  // word width in bits
   localparam int DEPTH_DEF  = 64;  // words, equals the NTT point count
   localparam int ADDR_W_DEF = 10;  // byte-address width of port 0
   localparam int RD_LAT_DEF = 2;   // port-0 read latency in clk edges

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      UNLOAD_RD,
      UNLOAD_WAIT,
      UNLOAD_OUT
   } state_t;

endpackage

// File: rtl/bram_sp_array.sv
// DEPTH x DATA_W word store with one write port and one read port whose
// result is delivered RD_LAT clk edges after the request. The read port is
// shared by two requesters, each with its own output register:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/idx/data    : write port (write lands on the same edge)
//   rd_idx            : word read by whichever requester is active
//   rd_p0, rd_p0_zero : port-0 read request; zero forces a 0 result
//   rd_fsm            : host sequencer read request
//   p0_clr            : clears the port-0 lane and its output register
//   p0_data, fsm_data : per-requester read results, held until replaced
// RD_LAT must be at least 2: one array-capture stage plus RD_LAT-2 extra
// stages feed the final output registers.
module bram_sp_array
   import ntt_bram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int RD_LAT = RD_LAT_DEF,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic              rd_p0,
   input  logic              rd_p0_zero,
   input  logic              rd_fsm,
   input  logic              p0_clr,
   output logic [DATA_W-1:0] p0_data,
   output logic [DATA_W-1:0] fsm_data
);

   localparam int NS = RD_LAT - 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] pipe_data_d [NS];
   logic [DATA_W-1:0] pipe_data_q [NS];
   logic [NS-1:0]     p0_v_d, p0_v_q;
   logic [NS-1:0]     p0_z_d, p0_z_q;
   logic [NS-1:0]     fsm_v_d, fsm_v_q;
   logic [DATA_W-1:0] p0_data_d, p0_data_q;
   logic [DATA_W-1:0] fsm_data_d, fsm_data_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_comb begin
      pipe_data_d[0] = mem[rd_idx];
      p0_v_d[0]      = rd_p0 & ~p0_clr;
      p0_z_d[0]      = rd_p0_zero;
      fsm_v_d[0]     = rd_fsm;
      for (int i = 1; i < NS; i++) begin
         pipe_data_d[i] = pipe_data_q[i-1];
         p0_v_d[i]      = p0_v_q[i-1] & ~p0_clr;
         p0_z_d[i]      = p0_z_q[i-1];
         fsm_v_d[i]     = fsm_v_q[i-1];
      end
      // Each output register only changes when its own read completes.
      p0_data_d = p0_data_q;
      if (p0_clr) begin
         p0_data_d = '0;
      end else if (p0_v_q[NS-1]) begin
         p0_data_d = p0_z_q[NS-1] ? '0 : pipe_data_q[NS-1];
      end
      fsm_data_d = fsm_v_q[NS-1] ? pipe_data_q[NS-1] : fsm_data_q;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NS; i++) pipe_data_q[i] <= pipe_data_d[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_v_q     <= '0;
         p0_z_q     <= '0;
         fsm_v_q    <= '0;
         p0_data_q  <= '0;
         fsm_data_q <= '0;
      end else begin
         p0_v_q     <= p0_v_d;
         p0_z_q     <= p0_z_d;
         fsm_v_q    <= fsm_v_d;
         p0_data_q  <= p0_data_d;
         fsm_data_q <= fsm_data_d;
      end
   end

   assign p0_data  = p0_data_q;
   assign fsm_data = fsm_data_q;

endmodule

// File: rtl/ntt_bram_responder.sv
// BRAM-style word store for an NTT engine (port 0, byte addressed) with a
// host sequencer that bulk-loads it from a valid/ready input stream and
// bulk-unloads it to a valid/ready output stream.
//   clk, rst                      : single clock, asynchronous active-low reset
//   BRAM_addr_0/din_0/dout_0      : engine port; word index = addr[ADDR_W-1:2]
//   BRAM_en_0/we_0/rst_0          : enable, write enable, output-register clear
//   s_valid/s_ready/s_data        : load stream into the store
//   m_valid/m_ready/m_data        : unload stream out of the store
//   load_start, unload_start      : one-cycle command pulses, honoured in IDLE
//   busy, load_done, unload_done  : sequencer status, done are 1-cycle pulses
//   addr_err                      : sticky out-of-range port-0 access flag
//   dbg_state                     : current sequencer state
// Stream handshakes: a beat transfers on a rising edge where valid and ready
// are both high; m_valid and m_data stay put until that edge.
module ntt_bram_responder
   import ntt_bram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] BRAM_addr_0,
   input  logic [DATA_W-1:0] BRAM_din_0,
   output logic [DATA_W-1:0] BRAM_dout_0,
   input  logic              BRAM_en_0,
   input  logic              BRAM_we_0,
   input  logic              BRAM_rst_0,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   input  logic              load_start,
   input  logic              unload_start,
   output logic              busy,
   output logic              load_done,
   output logic              unload_done,
   output logic              addr_err,
   output logic [2:0]        dbg_state
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int WORD_W = ADDR_W - 2;
   localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

   logic [WORD_W-1:0] p0_word;
   logic [IDX_W-1:0]  p0_idx;
   logic              p0_in_range;
   logic              unused_addr_lsb;

   assign p0_word         = BRAM_addr_0[ADDR_W-1:2];
   assign p0_idx          = p0_word[IDX_W-1:0];
   assign p0_in_range     = (32'(p0_word) < 32'(DEPTH));
   assign unused_addr_lsb = ^BRAM_addr_0[1:0];

   state_t            state_d, state_q;
   logic [IDX_W-1:0]  cnt_d, cnt_q;
   logic [WAIT_W-1:0] wait_d, wait_q;
   logic              s_ready_d, s_ready_q;
   logic              m_valid_d, m_valid_q;
   logic              busy_d, busy_q;
   logic              load_done_d, load_done_q;
   logic              unload_done_d, unload_done_q;
   logic              addr_err_d, addr_err_q;
   logic              fsm_wr, fsm_rd;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wait_d        = wait_q;
      load_done_d   = 1'b0;
      unload_done_d = 1'b0;
      fsm_wr        = 1'b0;
      fsm_rd        = 1'b0;
      case (state_q)
         IDLE: begin
            // A simultaneous unload request loses to load and is discarded.
            if (load_start)        state_d = LOAD;
            else if (unload_start) state_d = UNLOAD_RD;
         end
         LOAD: begin
            if (s_valid && s_ready_q) begin
               fsm_wr = 1'b1;
               if (cnt_q == IDX_W'(DEPTH - 1)) begin
                  cnt_d       = '0;
                  load_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         UNLOAD_RD: begin
            fsm_rd  = 1'b1;
            wait_d  = '0;
            state_d = UNLOAD_WAIT;
         end
         UNLOAD_WAIT: begin
            if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = UNLOAD_OUT;
            else                               wait_d  = wait_q + 1'b1;
         end
         UNLOAD_OUT: begin
            if (m_ready) begin
               if (cnt_q == IDX_W'(DEPTH - 1)) begin
                  cnt_d         = '0;
                  unload_done_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = UNLOAD_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Status outputs are registered copies of the next-state decode.
      busy_d     = (state_d != IDLE);
      s_ready_d  = (state_d == LOAD);
      m_valid_d  = (state_d == UNLOAD_OUT);
      // Engine accesses while the sequencer owns the store never flag errors.
      addr_err_d = addr_err_q | (BRAM_en_0 & ~busy_q & ~p0_in_range);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         wait_q        <= '0;
         s_ready_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         busy_q        <= 1'b0;
         load_done_q   <= 1'b0;
         unload_done_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wait_q        <= wait_d;
         s_ready_q     <= s_ready_d;
         m_valid_q     <= m_valid_d;
         busy_q        <= busy_d;
         load_done_q   <= load_done_d;
         unload_done_q <= unload_done_d;
         addr_err_q    <= addr_err_d;
      end
   end

   // The sequencer owns both array ports while busy; engine reads still
   // travel down the pipeline but come back as zero.
   logic              arr_wr_en;
   logic [IDX_W-1:0]  arr_idx;
   logic [DATA_W-1:0] arr_wr_data;

   assign arr_wr_en   = busy_q ? fsm_wr : (BRAM_en_0 & BRAM_we_0 & p0_in_range);
   assign arr_idx     = busy_q ? cnt_q  : p0_idx;
   assign arr_wr_data = busy_q ? s_data : BRAM_din_0;

   bram_sp_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) u_array (
      .clk        (clk),
      .rst_n      (rst),
      .wr_en      (arr_wr_en),
      .wr_idx     (arr_idx),
      .wr_data    (arr_wr_data),
      .rd_idx     (arr_idx),
      .rd_p0      (BRAM_en_0 & ~BRAM_we_0),
      .rd_p0_zero (busy_q | ~p0_in_range),
      .rd_fsm     (fsm_rd),
      .p0_clr     (BRAM_rst_0),
      .p0_data    (BRAM_dout_0),
      .fsm_data   (m_data)
   );

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign busy        = busy_q;
   assign load_done   = load_done_q;
   assign unload_done = unload_done_q;
   assign addr_err    = addr_err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ntt_bram_responder.sv
module tb_ntt_bram_responder;

  localparam int DW = 64;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic [AW-1:0] bram_addr = '0;
  logic [DW-1:0] bram_din = '0;
  logic [DW-1:0] bram_dout;
  logic          bram_en = 1'b0, bram_we = 1'b0, bram_rst = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          load_start = 1'b0, unload_start = 1'b0;
  logic          busy, load_done, unload_done, addr_err;
  logic [2:0]    dbg_state;

  ntt_bram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .BRAM_addr_0  (bram_addr),
    .BRAM_din_0   (bram_din),
    .BRAM_dout_0  (bram_dout),
    .BRAM_en_0    (bram_en),
    .BRAM_we_0    (bram_we),
    .BRAM_rst_0   (bram_rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .load_start   (load_start),
    .unload_start (unload_start),
    .busy         (busy),
    .load_done    (load_done),
    .unload_done  (unload_done),
    .addr_err     (addr_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int ld_cnt = 0;
  int ud_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (hold_pend) begin
        n_vec++;
        if (!m_valid || m_data !== hold_data) begin
          n_err++;
          $display("FAIL m_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   m_valid, m_data, hold_data);
        end
      end
      if (m_valid && m_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL m_extra: got beat %0h expected no beat", m_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_err++;
            $display("FAIL m_data: got %0h expected %0h", m_data, e);
          end
        end
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (load_done)   ld_cnt++;
      if (unload_done) ud_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},        DW'(busy),        '0);
    chk({tag, "_s_ready"},     DW'(s_ready),     '0);
    chk({tag, "_m_valid"},     DW'(m_valid),     '0);
    chk({tag, "_load_done"},   DW'(load_done),   '0);
    chk({tag, "_unload_done"}, DW'(unload_done), '0);
    chk({tag, "_addr_err"},    DW'(addr_err),    '0);
    chk({tag, "_dout"},        bram_dout,        '0);
    chk({tag, "_m_data"},      m_data,           '0);
  endtask

  task automatic p0_read(input int idx, input string name, input logic [DW-1:0] exp);
    bram_addr = AW'(idx * 4);
    bram_en = 1'b1;
    bram_we = 1'b0;
    tick();
    tick();
    bram_en = 1'b0;
    chk(name, bram_dout, exp);
  endtask

  // Runs an unload whose expected words are already queued; m_ready pattern
  // selects continuous or toggling back-pressure.
  task automatic run_unload(input int target_done, input bit toggle, input string name);
    int c;
    c = 0;
    while (ud_cnt < target_done && c < 3000) begin
      m_ready = toggle ? ((c % 4) < 2) : 1'b1;
      tick();
      c++;
    end
    m_ready = 1'b0;
    tick();
    chk({name, "_done_cnt"}, DW'(ud_cnt), DW'(target_done));
    chk({name, "_queue_left"}, DW'(exp_q.size()), '0);
    chk({name, "_idle"}, DW'(busy), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Load 64 beats i*3+1 with occasional gaps.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_s_ready", DW'(s_ready), 1);
    for (int i = 0; i < 64; i++) begin
      if (i % 7 == 3) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data = DW'(i * 3 + 1);
      tick();
      if (i == 62) chk("load_done_early", DW'(load_done), 0);
      if (i == 63) begin
        chk("load_done_pulse", DW'(load_done), 1);
        chk("load_idle", DW'(busy), 0);
      end
    end
    s_valid = 1'b0;
    tick();
    chk("load_done_once", DW'(ld_cnt), 1);

    // Port-0 read of word 5: value appears after exactly two edges.
    bram_addr = AW'(4 * 5);
    bram_en = 1'b1;
    tick();
    chk("rd5_edge1", bram_dout, 0);
    tick();
    bram_en = 1'b0;
    chk("rd5_edge2", bram_dout, 16);
    tick();
    chk("rd5_hold", bram_dout, 16);

    // Port-0 write of word 63, then unload with toggling m_ready.
    bram_addr = AW'(4 * 63);
    bram_din = 64'hA5A5;
    bram_en = 1'b1;
    bram_we = 1'b1;
    tick();
    bram_en = 1'b0;
    bram_we = 1'b0;
    for (int i = 0; i < 64; i++) exp_q.push_back(i == 63 ? 64'hA5A5 : DW'(i * 3 + 1));
    unload_start = 1'b1;
    tick();
    unload_start = 1'b0;
    run_unload(1, 1'b1, "unload1");

    // Out-of-range index 64: write dropped, read returns 0, addr_err sticky.
    bram_addr = 10'h100;
    bram_din = 64'hDEAD;
    bram_en = 1'b1;
    bram_we = 1'b1;
    tick();
    bram_we = 1'b0;
    tick();
    chk("oor_rd_edge1", bram_dout, 16);
    tick();
    bram_en = 1'b0;
    chk("oor_rd_zero", bram_dout, 0);
    chk("oor_addr_err", DW'(addr_err), 1);
    tick();
    tick();
    chk("oor_addr_err_held", DW'(addr_err), 1);
    p0_read(0, "oor_mem0_intact", 1);

    // Both starts together: LOAD wins; a later unload_start is ignored.
    load_start = 1'b1;
    unload_start = 1'b1;
    tick();
    load_start = 1'b0;
    unload_start = 1'b0;
    chk("both_s_ready", DW'(s_ready), 1);
    chk("both_m_valid", DW'(m_valid), 0);
    unload_start = 1'b1;
    tick();
    unload_start = 1'b0;
    chk("ign_unload_s_ready", DW'(s_ready), 1);
    chk("ign_unload_dbg_state", DW'(dbg_state), 1);

    // Ten beats, then reset lands on beat 10.
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = DW'(100 + i);
      tick();
      chk("ld2_m_valid", DW'(m_valid), 0);
    end
    s_data = DW'(110);
    rst = 1'b0;
    #1;
    s_valid = 1'b0;
    chk_reset_outputs("mid_load_rst");
    tick();
    tick();
    chk("rst_no_load_done", DW'(ld_cnt), 1);

    // First command after release is taken on the first edge.
    rst = 1'b1;
    for (int i = 0; i < 64; i++)
      exp_q.push_back(i < 10 ? DW'(100 + i) : (i == 63 ? 64'hA5A5 : DW'(i * 3 + 1)));
    unload_start = 1'b1;
    tick();
    unload_start = 1'b0;
    chk("first_cmd_busy", DW'(busy), 1);
    run_unload(2, 1'b0, "unload2");

    // Output-register clear after a read, then re-read of word 2.
    p0_read(2, "rd2_before_clr", 102);
    bram_rst = 1'b1;
    tick();
    bram_rst = 1'b0;
    chk("clr_dout_zero", bram_dout, 0);
    p0_read(2, "rd2_after_clr", 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
